rs_latch: RTL and testbench
===========================

# rs_latch

Clocked set/reset storage element: a bank of `WIDTH` independent RS bits with a registered output, replacing asynchronous cross-coupled latches in the design. Each bit is set by `s`, cleared by `r`, and holds otherwise. The forbidden `r=s=1` case is resolved by a build-time policy and flagged. It sits wherever a sticky flag or event-capture bit is needed.

## Interface
- `WIDTH`, default 1: number of independent RS bits.
- `CONFLICT_MODE`, default `RESET_DOMINANT`: resolution of `r=s=1`. One of `RESET_DOMINANT`, `SET_DOMINANT`, `HOLD`, `TOGGLE`.
- `RESET_VALUE`, default all-zeros (`WIDTH` bits): value loaded into `q` on `rst`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `r`  in  WIDTH  per-bit reset (clear) request.
- `s`  in  WIDTH  per-bit set request.
- `q`  out  WIDTH  stored state.
- `qn`  out  WIDTH  `~q`, always the exact complement.
- `conflict`  out  WIDTH  registered per-bit flag: high for one cycle after a cycle where `r=s=1`.

## Operation
- Per bit `i`, at each rising `clk` edge with `rst=0`, `q[i]` is updated as follows:
  - `r=0, s=0`: hold.
  - `r=1, s=0`: `q[i] <= 0`.
  - `r=0, s=1`: `q[i] <= 1`.
  - `r=1, s=1`: resolved by `CONFLICT_MODE`:
    - `RESET_DOMINANT`: `q[i] <= 0`.
    - `SET_DOMINANT`: `q[i] <= 1`.
    - `HOLD`: `q[i]` is unchanged.
    - `TOGGLE`: `q[i] <= ~q[i]`.
- `conflict[i] <= r[i] & s[i]` every cycle, independently of mode.
- Bits are fully independent. There is no cross-bit interaction.
- `qn` is derived combinationally from `q`. It is never separately stored, so `q` and `qn` can never be equal.
- An unknown value on `r` or `s` must not be masked in simulation. X propagation is acceptable.

## Timing
- All updates occur on the rising edge of `clk`. Latency from `r`/`s` to `q` is exactly 1 cycle.
- No combinational path exists from `r`/`s` to `q`, `qn` or `conflict`.
- Reset (synchronous, active-high) applies at the edge where `rst=1`:
  - `q <= RESET_VALUE`
  - `conflict <= 0`
  - `qn = ~RESET_VALUE`
- `rst` has priority over `r`/`s` in the same cycle.
- Reset asserted mid-operation discards the held state. Deassertion resumes normal behaviour on the next edge.
- Before the first reset or the first set/clear, `q` is undefined. A single `r=1` cycle alone must drive `q` to a defined 0.
- Inputs held for many cycles give steady-state behaviour:
  - `q` stays at the last set or cleared value.
  - `conflict` stays high while `r=s=1`.

## Structure
- Package `rs_latch_pkg` holds the `conflict_mode_e` enum (`RESET_DOMINANT`, `SET_DOMINANT`, `HOLD`, `TOGGLE`) and a next-state function `rs_next(q, r, s, mode)`.
- Sub-module `rs_cell`: a one-bit register with reset value, next-state logic and conflict flag. `rs_latch` instantiates `WIDTH` copies in a generate loop.
- The top level contains only parameter checks (`WIDTH >= 1`, valid mode) and the `qn` assignment.

## Test plan
- Default parameters, reset applied: `rst=1` for one edge, then `r=1, s=0` → `q=0` one edge later; `r=0, s=0` → `q` holds 0; `r=0, s=1` → `q=1`; `r=0, s=0` → `q` holds 1; `qn` is the complement at every step.
- Conflict, each mode, starting from `q=1`: `r=s=1` for one cycle gives `q` = 0 / 1 / 1 / 0 for RESET_DOMINANT / SET_DOMINANT / HOLD / TOGGLE; `conflict=1` for exactly that one following cycle.
- TOGGLE held: `r=s=1` for 4 cycles from `q=0` → `q` sequence 1, 0, 1, 0.
- Reset priority: `q=1`, then `rst=1` with `s=1` in the same cycle → `q=RESET_VALUE` (0); `RESET_VALUE=1` variant → `q=1`, `conflict=0`.
- `WIDTH=8` independence: `s=8'h0F`, then `r=8'h03` → `q=8'h0C`; `r=8'h80, s=8'h80` (reset-dominant) → `q=8'h0C`, `conflict=8'h80`.
- No-reset start: `q` is X, then a single `r=1` edge → `q=0`.

Source files
------------

// File: rtl/rs_latch_pkg.sv
// rs_latch_pkg
//
// Shared definitions for the clocked RS storage bank:
//   conflict_mode_e : how a bit resolves a simultaneous set and clear request
//   rs_next()       : next value of a single RS bit given its current value,
//                     the clear/set requests and the conflict mode
package rs_latch_pkg;

    typedef enum logic [1:0] {
        RESET_DOMINANT = 2'd0,
        SET_DOMINANT   = 2'd1,
        HOLD           = 2'd2,
        TOGGLE         = 2'd3
    } conflict_mode_e;

    // The next-state equations are written as plain logic rather than a
    // case on {r, s}, so an unknown request propagates as X in simulation
    // instead of silently falling into a default branch.
    function automatic logic rs_next(
        input logic           q,
        input logic           r,
        input logic           s,
        input conflict_mode_e mode
    );
        logic next_q;
        next_q = q;
        case (mode)
            RESET_DOMINANT: next_q = ~r & (s | q);
            SET_DOMINANT:   next_q = s | (~r & q);
            HOLD:           next_q = (s & ~r) | (q & ~(r ^ s));
            TOGGLE:         next_q = (s & ~r) | (q & ~r & ~s) | (~q & r & s);
            default:        next_q = q;
        endcase
        return next_q;
    endfunction

endpackage

// File: rtl/rs_cell.sv
// rs_cell
//
// One clocked RS bit with a registered conflict flag.
//
// Ports:
//   clk      in  rising-edge clock
//   rst      in  synchronous active-high reset, loads RESET_VALUE
//   r        in  clear request
//   s        in  set request
//   q        out stored bit
//   conflict out high for one cycle after a cycle with r = s = 1
module rs_cell
    import rs_latch_pkg::*;
#(
    parameter conflict_mode_e CONFLICT_MODE = RESET_DOMINANT,
    parameter logic           RESET_VALUE   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic r,
    input  logic s,
    output logic q,
    output logic conflict
);

    // State and conflict flag share one register stage so both respond to
    // the same input cycle; reset wins over any request in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q        <= RESET_VALUE;
            conflict <= 1'b0;
        end else begin
            q        <= rs_next(q, r, s, CONFLICT_MODE);
            conflict <= r & s;
        end
    end

endmodule

// File: rtl/rs_latch.sv
// rs_latch
//
// Bank of WIDTH independent clocked RS bits, used wherever a sticky flag or
// event-capture bit is needed in place of a cross-coupled latch.
//
// Ports:
//   clk      in  rising-edge clock
//   rst      in  synchronous active-high reset, q <= RESET_VALUE
//   r        in  [WIDTH] per-bit clear request
//   s        in  [WIDTH] per-bit set request
//   q        out [WIDTH] stored state
//   qn       out [WIDTH] exact complement of q
//   conflict out [WIDTH] per-bit flag, high one cycle after r = s = 1
module rs_latch
    import rs_latch_pkg::*;
#(
    parameter int             WIDTH         = 1,
    parameter conflict_mode_e CONFLICT_MODE = RESET_DOMINANT,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] conflict
);

    // Reject nonsensical builds at elaboration time.
    if (WIDTH < 1) begin : g_bad_width
        $error("rs_latch: WIDTH must be at least 1");
    end

    if (CONFLICT_MODE != RESET_DOMINANT && CONFLICT_MODE != SET_DOMINANT &&
        CONFLICT_MODE != HOLD && CONFLICT_MODE != TOGGLE) begin : g_bad_mode
        $error("rs_latch: CONFLICT_MODE is not a valid conflict_mode_e value");
    end

    // Bits never interact, so each gets its own cell.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        rs_cell #(
            .CONFLICT_MODE (CONFLICT_MODE),
            .RESET_VALUE   (RESET_VALUE[i])
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .r        (r[i]),
            .s        (s[i]),
            .q        (q[i]),
            .conflict (conflict[i])
        );
    end

    // qn is derived rather than stored, so it can never disagree with q.
    assign qn = ~q;

endmodule

// File: tb/tb_rs_latch.sv
// tb_rs_latch
//
// Drives a default-parameter instance plus four WIDTH=8 instances (one per
// conflict mode, with differing reset values) and compares every output
// against a bit-level reference model after each clock edge.
module tb_rs_latch;
    import rs_latch_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the 8-bit bank
    logic         rst;
    logic [W-1:0] r;
    logic [W-1:0] s;
    logic [W-1:0] q_m  [4];
    logic [W-1:0] qn_m [4];
    logic [W-1:0] c_m  [4];

    // Default-parameter instance has its own stimulus
    logic rst_d, r_d, s_d;
    logic q_d, qn_d, c_d;

    // Reference model state
    logic [W-1:0] mq [4];
    logic [W-1:0] mc [4];

    int checks   = 0;
    int failures = 0;

    function automatic logic [W-1:0] resetValueOf(int m);
        case (m)
            1:       return 8'hFF;
            3:       return 8'hA5;
            default: return 8'h00;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        rs_latch #(
            .WIDTH         (W),
            .CONFLICT_MODE (conflict_mode_e'(g)),
            .RESET_VALUE   (resetValueOf(g))
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .r        (r),
            .s        (s),
            .q        (q_m[g]),
            .qn       (qn_m[g]),
            .conflict (c_m[g])
        );
    end

    rs_latch dut_def (
        .clk      (clk),
        .rst      (rst_d),
        .r        (r_d),
        .s        (s_d),
        .q        (q_d),
        .qn       (qn_d),
        .conflict (c_d)
    );

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: applies the RS rules bit by bit for each mode.
    task automatic modelStep(input logic rr, input logic [W-1:0] rv, input logic [W-1:0] sv);
        for (int m = 0; m < 4; m++) begin
            if (rr) begin
                mq[m] = resetValueOf(m);
                mc[m] = '0;
            end else begin
                for (int b = 0; b < W; b++) begin
                    if (rv[b] && sv[b]) begin
                        case (m)
                            0:       mq[m][b] = 1'b0;
                            1:       mq[m][b] = 1'b1;
                            2:       mq[m][b] = mq[m][b];
                            default: mq[m][b] = !mq[m][b];
                        endcase
                    end else if (rv[b]) begin
                        mq[m][b] = 1'b0;
                    end else if (sv[b]) begin
                        mq[m][b] = 1'b1;
                    end
                    mc[m][b] = rv[b] && sv[b];
                end
            end
        end
    endtask

    // Drive the bank for one cycle, advance the model, check all instances.
    task automatic applyStimulus(input logic rr, input logic [W-1:0] rv, input logic [W-1:0] sv);
        rst = rr;
        r   = rv;
        s   = sv;
        @(posedge clk);
        modelStep(rr, rv, sv);
        #1;
        for (int m = 0; m < 4; m++) begin
            checkOutput($sformatf("bank%0d_q", m),        q_m[m],  mq[m]);
            checkOutput($sformatf("bank%0d_qn", m),       qn_m[m], ~mq[m]);
            checkOutput($sformatf("bank%0d_conflict", m), c_m[m],  mc[m]);
        end
    endtask

    // Drive the default instance for one cycle and check against constants.
    task automatic applyDefault(input string tag, input logic rr, input logic rv, input logic sv,
                                input logic exp_q, input logic exp_c);
        rst_d = rr;
        r_d   = rv;
        s_d   = sv;
        @(posedge clk);
        #1;
        checkOutput({tag, "_q"},        {7'b0, q_d},  {7'b0, exp_q});
        checkOutput({tag, "_qn"},       {7'b0, qn_d}, {7'b0, ~exp_q});
        checkOutput({tag, "_conflict"}, {7'b0, c_d},  {7'b0, exp_c});
    endtask

    initial begin
        rst   = 1'b1;
        r     = '0;
        s     = '0;
        rst_d = 1'b0;
        r_d   = 1'b0;
        s_d   = 1'b0;
        #2;

        // Default instance, starting without any reset: a lone clear defines q
        applyDefault("def_noreset_clear", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyDefault("def_reset",         1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyDefault("def_clear",         1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyDefault("def_hold0",         1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyDefault("def_set",           1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyDefault("def_hold1",         1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyDefault("def_conflict",      1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        applyDefault("def_after_conf",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyDefault("def_set2",          1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyDefault("def_rst_priority",  1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Bank: width independence with reset-dominant conflict
        applyStimulus(1'b1, 8'h00, 8'h00);
        applyStimulus(1'b0, 8'h00, 8'h0F);
        applyStimulus(1'b0, 8'h03, 8'h00);
        checkOutput("rd_partial_clear", q_m[0], 8'h0C);
        applyStimulus(1'b0, 8'h80, 8'h80);
        checkOutput("rd_conflict_q",    q_m[0], 8'h0C);
        checkOutput("rd_conflict_flag", c_m[0], 8'h80);
        applyStimulus(1'b0, 8'h00, 8'h00);
        checkOutput("rd_conflict_drop", c_m[0], 8'h00);

        // Conflict from q=1 in every mode
        applyStimulus(1'b0, 8'h00, 8'hFF);
        applyStimulus(1'b0, 8'hFF, 8'hFF);
        checkOutput("mode_rd_q",  q_m[0], 8'h00);
        checkOutput("mode_sd_q",  q_m[1], 8'hFF);
        checkOutput("mode_hd_q",  q_m[2], 8'hFF);
        checkOutput("mode_tg_q",  q_m[3], 8'h00);

        // Toggle held for four cycles from the A5 reset value
        applyStimulus(1'b1, 8'h00, 8'h00);
        checkOutput("tg_reset_value", q_m[3], 8'hA5);
        applyStimulus(1'b0, 8'hFF, 8'hFF);
        checkOutput("tg_1", q_m[3], 8'h5A);
        applyStimulus(1'b0, 8'hFF, 8'hFF);
        checkOutput("tg_2", q_m[3], 8'hA5);
        applyStimulus(1'b0, 8'hFF, 8'hFF);
        checkOutput("tg_3", q_m[3], 8'h5A);
        applyStimulus(1'b0, 8'hFF, 8'hFF);
        checkOutput("tg_4", q_m[3], 8'hA5);

        // Reset beats a set request in the same cycle
        applyStimulus(1'b0, 8'h00, 8'hFF);
        applyStimulus(1'b1, 8'h00, 8'hFF);
        checkOutput("rst_priority_rd", q_m[0], 8'h00);
        checkOutput("rst_priority_sd", q_m[1], 8'hFF);
        checkOutput("rst_priority_cf", c_m[1], 8'h00);

        // Randomised traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            logic         rr;
            logic [W-1:0] rv;
            logic [W-1:0] sv;
            rr = ($urandom_range(0, 29) == 0);
            rv = W'($urandom);
            sv = W'($urandom);
            if ($urandom_range(0, 3) == 0) rv = '0;
            if ($urandom_range(0, 3) == 0) sv = '0;
            applyStimulus(rr, rv, sv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
